// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: aluop codes, result classes, FSM states.
// The DIV_BUSY state only exists when EX_DIV_EN is defined.
package ex_pkg;

   localparam logic        RstEnable = 1'b1;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;

   localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
   localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
   localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
   localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
   localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
   localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

   typedef enum logic [2:0] {
      SEL_NOP, SEL_LOGIC, SEL_SHIFT, SEL_ARITH, SEL_MOVE, SEL_HILO, SEL_MULDIV
   } alusel_e;

`ifdef EX_DIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV_BUSY = 2'd1, S_DONE = 2'd2} ex_state_e;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} ex_state_e;
`endif

   function automatic alusel_e alusel_of(input logic [7:0] op);
      case (op)
         EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP:        return SEL_LOGIC;
         EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:                   return SEL_SHIFT;
         EXE_ADD_OP, EXE_ADDIU_OP, EXE_SUB_OP,
         EXE_SLT_OP, EXE_SLTU_OP:                              return SEL_ARITH;
         EXE_MFHI_OP, EXE_MFLO_OP:                             return SEL_MOVE;
         EXE_MTHI_OP, EXE_MTLO_OP:                             return SEL_HILO;
         EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP:   return SEL_MULDIV;
         default:                                              return SEL_NOP;
      endcase
   endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle over WIDTH cycles.
// Only built when EX_DIV_EN is defined.
`ifdef EX_DIV_EN
module ex_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             sgn,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic             neg_quo_q, neg_rem_q;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   partial, diff;

   assign a_mag = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
   assign b_mag = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

   // quo_q starts as the dividend and shifts quotient bits in from the LSB
   assign partial = {rem_q, quo_q[WIDTH-1]};
   assign diff    = partial - {1'b0, dvs_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (abort) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q     <= CW'(WIDTH);
         rem_q     <= '0;
         quo_q     <= a_mag;
         dvs_q     <= b_mag;
         neg_quo_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_rem_q <= sgn & dividend[WIDTH-1];
      end else if (busy) begin
         cnt_q <= cnt_q - 1'b1;
         if (diff[WIDTH]) begin
            rem_q <= partial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end else begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign busy      = (cnt_q != '0);
   assign last      = (cnt_q == CW'(1));
   assign quotient  = neg_quo_q ? -quo_q : quo_q;
   assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule
`endif

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle ALU, two-cycle multiplier, iterative divider, HI/LO.
// Define EX_DIV_EN to build the divider; otherwise DIV/DIVU retire as NOPs.
module ex_muldiv
   import ex_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic                  flush_i,
   input  logic [ALUOP_W-1:0]    aluop_i,
   input  logic [WIDTH-1:0]      reg1_i,
   input  logic [WIDTH-1:0]      reg2_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   output logic                  stallreq_o,
   output logic                  valid_o,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [WIDTH-1:0]      wdata_o,
   output logic [WIDTH-1:0]      hi_o,
   output logic [WIDTH-1:0]      lo_o
);
   localparam int SHW = $clog2(WIDTH);

   ex_state_e          state_q, state_d;
   logic [7:0]         op;
   alusel_e            sel;
   logic               is_mul, wr_class;
   logic [WIDTH-1:0]   hi_q, lo_q, alu_res;
   logic [2*WIDTH-1:0] mul_a, mul_b, product, res_q;

   assign op       = 8'(aluop_i);
   assign sel      = alusel_of(op);
   assign is_mul   = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
   assign wr_class = sel inside {SEL_LOGIC, SEL_SHIFT, SEL_ARITH, SEL_MOVE};
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;

`ifdef EX_DIV_EN
   logic             is_div, div_zero, div_start, div_busy, div_last, res_div_q;
   logic [WIDTH-1:0] div_quo, div_rem;

   assign is_div   = (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   assign div_zero = (reg2_i == '0);

   ex_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (flush_i),
      .sgn       (op == EXE_DIV_OP),
      .dividend  (reg1_i),
      .divisor   (reg2_i),
      .busy      (div_busy),
      .last      (div_last),
      .quotient  (div_quo),
      .remainder (div_rem)
   );
`endif

   always_comb begin
      alu_res = '0;
      case (op)
         EXE_AND_OP:               alu_res = reg1_i & reg2_i;
         EXE_OR_OP:                alu_res = reg1_i | reg2_i;
         EXE_XOR_OP:               alu_res = reg1_i ^ reg2_i;
         EXE_NOR_OP:               alu_res = ~(reg1_i | reg2_i);
         EXE_SLL_OP:               alu_res = reg2_i << reg1_i[SHW-1:0];
         EXE_SRL_OP:               alu_res = reg2_i >> reg1_i[SHW-1:0];
         EXE_SRA_OP:               alu_res = $unsigned($signed(reg2_i) >>> reg1_i[SHW-1:0]);
         EXE_ADD_OP, EXE_ADDIU_OP: alu_res = reg1_i + reg2_i;
         EXE_SUB_OP:               alu_res = reg1_i - reg2_i;
         EXE_SLT_OP:               alu_res = {{(WIDTH-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
         EXE_SLTU_OP:              alu_res = {{(WIDTH-1){1'b0}}, reg1_i < reg2_i};
         EXE_MFHI_OP:              alu_res = hi_q;
         EXE_MFLO_OP:              alu_res = lo_q;
         default:                  alu_res = '0;
      endcase
   end

   // Sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both forms
   always_comb begin
      mul_a = {{WIDTH{1'b0}}, reg1_i};
      mul_b = {{WIDTH{1'b0}}, reg2_i};
      if (op == EXE_MULT_OP) begin
         mul_a = {{WIDTH{reg1_i[WIDTH-1]}}, reg1_i};
         mul_b = {{WIDTH{reg2_i[WIDTH-1]}}, reg2_i};
      end
      product = mul_a * mul_b;
   end

   always_comb begin
      state_d    = state_q;
      stallreq_o = 1'b0;
`ifdef EX_DIV_EN
      div_start  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (valid_i && is_mul) begin
               stallreq_o = 1'b1;
               state_d    = S_DONE;
            end
`ifdef EX_DIV_EN
            else if (valid_i && is_div) begin
               stallreq_o = 1'b1;
               div_start  = !div_zero;
               state_d    = div_zero ? S_DONE : S_DIV_BUSY;
            end
`endif
         end
`ifdef EX_DIV_EN
         S_DIV_BUSY: begin
            stallreq_o = div_busy;
            if (div_last) state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush_i || rst) begin
         state_d    = S_IDLE;
         stallreq_o = 1'b0;
`ifdef EX_DIV_EN
         div_start  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q   <= S_IDLE;
         valid_o   <= 1'b0;
         wd_o      <= '0;
         wreg_o    <= 1'b0;
         wdata_o   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         res_q     <= '0;
`ifdef EX_DIV_EN
         res_div_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         valid_o <= 1'b0;
         wd_o    <= '0;
         wreg_o  <= 1'b0;
         wdata_o <= '0;
         if (!flush_i) begin
            case (state_q)
               S_IDLE: begin
                  if (valid_i && is_mul) begin
                     res_q     <= product;
`ifdef EX_DIV_EN
                     res_div_q <= 1'b0;
                  end else if (valid_i && is_div) begin
                     // divide-by-zero result is staged here; otherwise DONE reads the divider
                     res_q     <= {reg1_i, {WIDTH{1'b1}}};
                     res_div_q <= !div_zero;
`endif
                  end else if (valid_i) begin
                     valid_o <= 1'b1;
                     wd_o    <= wd_i;
                     wreg_o  <= wreg_i & wr_class;
                     wdata_o <= alu_res;
                     if (op == EXE_MTHI_OP) hi_q <= reg1_i;
                     if (op == EXE_MTLO_OP) lo_q <= reg1_i;
                  end
               end
               S_DONE: begin
                  valid_o <= 1'b1;
`ifdef EX_DIV_EN
                  if (res_div_q) {hi_q, lo_q} <= {div_rem, div_quo};
                  else           {hi_q, lo_q} <= res_q;
`else
                  {hi_q, lo_q} <= res_q;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus random ops against a spec-level model.
module tb_ex_muldiv;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst, valid_i, flush_i, wreg_i;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        stallreq_o, valid_o, wreg_o;
   logic [4:0]  wd_o;
   logic [31:0] wdata_o, hi_o, lo_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] hi_m = 32'h0, lo_m = 32'h0;

   ex_muldiv #(.WIDTH(32), .REG_ADDR_W(5), .ALUOP_W(8)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .stallreq_o(stallreq_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
      .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: got still running want finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a, b);
      int unsigned sh = a % 32;
      longint      sa = $signed(a);
      longint      sb = $signed(b);
      case (op)
         EXE_AND_OP:               return a & b;
         EXE_OR_OP:                return a | b;
         EXE_XOR_OP:               return a ^ b;
         EXE_NOR_OP:               return ~(a | b);
         EXE_SLL_OP:               return 32'(longint'(b) * (longint'(1) << sh));
         EXE_SRL_OP:               return 32'(longint'(b) / (longint'(1) << sh));
         EXE_SRA_OP:               return 32'((sb < 0) ? -((-sb - 1) / (longint'(1) << sh)) - 1
                                                       : sb / (longint'(1) << sh));
         EXE_ADD_OP, EXE_ADDIU_OP: return 32'(longint'(a) + longint'(b));
         EXE_SUB_OP:               return 32'(longint'(a) - longint'(b));
         EXE_SLT_OP:               return (sa < sb) ? 32'd1 : 32'd0;
         EXE_SLTU_OP:              return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         EXE_MFHI_OP:              return hi_m;
         EXE_MFLO_OP:              return lo_m;
         default:                  return 32'd0;
      endcase
   endfunction

   // Issue one op at the next negedge, count stall cycles, check the retire edge.
   task automatic run_op(input logic [7:0] op, input logic [31:0] a, b,
                         input logic [4:0] wd, input logic wr);
      logic [31:0] eh, el, ew;
      logic        ewr, mc;
      int          stalls, exp_st;
      longint      p;
      eh = hi_m; el = lo_m; ew = 32'd0; ewr = wr; exp_st = 0; mc = 1'b0;
      case (op)
         EXE_MULT_OP:  begin p = longint'($signed(a)) * longint'($signed(b)); {eh, el} = p; exp_st = 1; mc = 1'b1; end
         EXE_MULTU_OP: begin p = longint'(a) * longint'(b); {eh, el} = p; exp_st = 1; mc = 1'b1; end
         EXE_DIV_OP, EXE_DIVU_OP: begin
            mc = 1'b1;
`ifdef EX_DIV_EN
            if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; exp_st = 1; end
            else begin
               exp_st = 33;
               if (op == EXE_DIV_OP) begin
                  el = 32'(longint'($signed(a)) / longint'($signed(b)));
                  eh = 32'(longint'($signed(a)) % longint'($signed(b)));
               end else begin
                  el = a / b; eh = a % b;
               end
            end
`endif
         end
         EXE_MTHI_OP: begin eh = a; ewr = 1'b0; end
         EXE_MTLO_OP: begin el = a; ewr = 1'b0; end
         default:     ew = ref_alu(op, a, b);
      endcase
      if (mc) ewr = 1'b0;
      @(negedge clk);
      aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; valid_i = 1'b1;
      #1;
      stalls = 0;
      while (stallreq_o && stalls < 100) begin
         stalls++;
         @(posedge clk); @(negedge clk); #1;
      end
      @(posedge clk); #1;
      chk($sformatf("stall op%h", op), 64'(stalls), 64'(exp_st));
      chk($sformatf("valid op%h", op), 64'(valid_o), 64'd1);
      chk($sformatf("wreg op%h", op), 64'(wreg_o), 64'(ewr));
      if (!mc) begin
         chk($sformatf("wdata op%h a=%h b=%h", op, a, b), 64'(wdata_o), 64'(ew));
         chk($sformatf("wd op%h", op), 64'(wd_o), 64'(wd));
      end
      chk($sformatf("hi op%h a=%h b=%h", op, a, b), 64'(hi_o), 64'(eh));
      chk($sformatf("lo op%h a=%h b=%h", op, a, b), 64'(lo_o), 64'(el));
      hi_m = eh; lo_m = el;
   endtask

   task automatic go_idle();
      @(negedge clk);
      valid_i = 1'b0; flush_i = 1'b0;
   endtask

   logic [7:0] ops[$] = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP,
                          EXE_SRL_OP, EXE_SRA_OP, EXE_ADD_OP, EXE_ADDIU_OP, EXE_SUB_OP,
                          EXE_SLT_OP, EXE_SLTU_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP,
                          EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};

   initial begin
      logic [7:0]  rop;
      logic [31:0] ra, rb;
      rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; aluop_i = EXE_NOP_OP;
      reg1_i = 32'd0; reg2_i = 32'd0; wd_i = 5'd0; wreg_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst valid", 64'(valid_o), 64'd0);
      chk("rst wdata", 64'(wdata_o), 64'd0);
      chk("rst wreg", 64'(wreg_o), 64'd0);
      chk("rst hi", 64'(hi_o), 64'd0);
      chk("rst lo", 64'(lo_o), 64'd0);
      chk("rst stall", 64'(stallreq_o), 64'd0);
      rst = 1'b0;

      // valid_i low: outputs stay quiet
      @(posedge clk); #1;
      chk("idle valid", 64'(valid_o), 64'd0);

      run_op(EXE_MTHI_OP, 32'h0000_1234, 32'd0, 5'd0, 1'b0);
      run_op(EXE_MFHI_OP, 32'd0, 32'd0, 5'd3, 1'b1);
      chk("mfhi bypass", 64'(wdata_o), 64'h1234);

      run_op(EXE_MULT_OP, 32'hFFFF_FFFF, 32'h2, 5'd1, 1'b1);
      chk("mult hi", 64'(hi_o), 64'hFFFF_FFFF);
      chk("mult lo", 64'(lo_o), 64'hFFFF_FFFE);
      run_op(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'h2, 5'd1, 1'b1);
      chk("multu hi", 64'(hi_o), 64'h1);
      chk("multu lo", 64'(lo_o), 64'hFFFF_FFFE);

`ifdef EX_DIV_EN
      run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h2, 5'd1, 1'b1);
      chk("div lo", 64'(lo_o), 64'hFFFF_FFFD);
      chk("div hi", 64'(hi_o), 64'hFFFF_FFFF);
      run_op(EXE_DIVU_OP, 32'd100, 32'd7, 5'd1, 1'b1);
      chk("divu lo", 64'(lo_o), 64'd14);
      chk("divu hi", 64'(hi_o), 64'd2);
      run_op(EXE_DIVU_OP, 32'h1234_5678, 32'd0, 5'd1, 1'b1);
      chk("div0 lo", 64'(lo_o), 64'hFFFF_FFFF);
      chk("div0 hi", 64'(hi_o), 64'h1234_5678);

      // flush in the 10th DIV_BUSY cycle
      @(negedge clk);
      aluop_i = EXE_DIV_OP; reg1_i = 32'd1000; reg2_i = 32'd3; valid_i = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("busy stall", 64'(stallreq_o), 64'd1);
      flush_i = 1'b1; #1;
      chk("flush stall", 64'(stallreq_o), 64'd0);
      @(posedge clk); #1;
      chk("flush valid", 64'(valid_o), 64'd0);
      go_idle(); #1;
      chk("post-flush stall", 64'(stallreq_o), 64'd0);
      repeat (40) @(posedge clk); #1;
      chk("flush hi", 64'(hi_o), 64'(hi_m));
      chk("flush lo", 64'(lo_o), 64'(lo_m));
`else
      run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h2, 5'd1, 1'b1);
      run_op(EXE_DIVU_OP, 32'd100, 32'd0, 5'd1, 1'b1);
`endif

      // flush on a MULT accept cycle: no stall, no HI/LO write
      @(negedge clk);
      aluop_i = EXE_MULT_OP; reg1_i = 32'd9; reg2_i = 32'd9; valid_i = 1'b1; flush_i = 1'b1; #1;
      chk("mflush stall", 64'(stallreq_o), 64'd0);
      @(posedge clk); #1;
      chk("mflush valid", 64'(valid_o), 64'd0);
      go_idle();
      repeat (3) @(posedge clk); #1;
      chk("mflush hi", 64'(hi_o), 64'(hi_m));
      chk("mflush lo", 64'(lo_o), 64'(lo_m));

      for (int i = 0; i < 160; i++) begin
         rop = ops[$urandom_range(0, ops.size() - 1)];
         if ((rop == EXE_DIV_OP || rop == EXE_DIVU_OP) && $urandom_range(0, 2) != 0) rop = EXE_SUB_OP;
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         run_op(rop, ra, rb, 5'($urandom), 1'($urandom));
      end

      // reset in the middle of a multi-cycle op
      run_op(EXE_MTHI_OP, 32'hABCD_0000, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
`ifdef EX_DIV_EN
      aluop_i = EXE_DIV_OP;
`else
      aluop_i = EXE_MULT_OP;
`endif
      reg1_i = 32'd100; reg2_i = 32'd7; valid_i = 1'b1;
      @(posedge clk); #2;
      rst = 1'b1; #1;
      chk("mid-rst hi", 64'(hi_o), 64'd0);
      chk("mid-rst lo", 64'(lo_o), 64'd0);
      chk("mid-rst valid", 64'(valid_o), 64'd0);
      chk("mid-rst wdata", 64'(wdata_o), 64'd0);
      chk("mid-rst stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      valid_i = 1'b0; rst = 1'b0;
      hi_m = 32'd0; lo_m = 32'd0;
      run_op(EXE_ADD_OP, 32'd5, 32'd7, 5'd2, 1'b1);
      chk("post-rst add", 64'(wdata_o), 64'd12);
      go_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised execute stage for the five-stage pipeline, successor to the single-cycle logic/shift/arithmetic EX stage. It keeps the single-cycle ALU operations, registers its result into the EX/MEM boundary, and owns the HI/LO register pair. It adds a two-cycle multiplier and a WIDTH-cycle radix-2 iterative divider, and raises a stall request while a multi-cycle operation is in flight. It sits between the ID/EX register and the MEM stage and drives the pipeline controller's stall input.

## Interface
- WIDTH, 32, datapath width in bits (even, ≥8)
- REG_ADDR_W, 5, register-file address width
- ALUOP_W, 8, width of the aluop code
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  ID/EX holds a live instruction
- flush_i  in  1  abort the instruction in EX, including any in-flight divide
- aluop_i  in  ALUOP_W  operation code (ex_pkg)
- reg1_i, reg2_i  in  WIDTH  source operands
- wd_i  in  REG_ADDR_W  destination address
- wreg_i  in  1  destination write enable
- stallreq_o  out  1  hold upstream stages; combinational
- valid_o  out  1  registered result valid
- wd_o  out  REG_ADDR_W  registered destination address
- wreg_o  out  1  registered write enable, gated by valid_o
- wdata_o  out  WIDTH  registered GPR result
- hi_o, lo_o  out  WIDTH  current HI/LO contents

One clock; reset is asynchronous and active-high. All outputs reset to 0. HI, LO, the FSM (state IDLE), and the counter also reset to 0.

## Operation
- Single-cycle ops:
  - OR, AND, NOR, XOR, SLL, SRL, SRA, ADD, ADDIU, SUB, SLT, SLTU.
  - Shifts use reg1_i[log2(WIDTH)-1:0] as the amount and reg2_i as the value.
  - ADD, ADDIU, and SUB wrap modulo 2^WIDTH. Overflow is not trapped.
  - SLT and SLTU return 1 or 0 zero-extended.
- MFHI and MFLO return HI/LO. MTHI and MTLO write reg1_i into HI or LO; wreg_o is 0.
- HI/LO bypass: a write committing at edge N is visible to MFHI/MFLO sampled in the cycle after edge N. This is required for back-to-back MTHI then MFHI.
- FSM states:
  - IDLE:
    - On valid_i with MULT or MULTU: register the 2·WIDTH product and go to DONE.
    - On DIV or DIVU with divisor ≠ 0: latch operand magnitudes and result signs, load counter = WIDTH, go to DIV_BUSY.
    - On DIV or DIVU with divisor = 0: result LO = all ones, HI = dividend; go to DONE.
    - On any other op: issue the single-cycle result.
  - DIV_BUSY: one restoring-division step per cycle. The counter decrements; at counter = 1 go to DONE.
  - DONE: write {HI, LO} from the result register, pulse valid_o with wreg_o = 0, return to IDLE. Inputs are ignored in this state.
- Signed divide: quotient is negated if the operand signs differ; remainder takes the dividend's sign. LO = quotient, HI = remainder.
- Signed multiply uses a 2·WIDTH two's-complement product. HI = upper half, LO = lower half.
- stallreq_o:
  - High in the IDLE accept cycle of MULT, MULTU, DIV, or DIVU.
  - High throughout DIV_BUSY.
  - Low in IDLE otherwise and low in DONE.
  - Upstream holds reg1_i, reg2_i, and aluop_i stable while stallreq_o is high.
- flush_i: from any state, the next state is IDLE. valid_o and wreg_o are 0 on the next edge, and HI/LO are unchanged. stallreq_o is forced low in the flush cycle.
- valid_i low in IDLE: the next edge gives valid_o = 0, wreg_o = 0, and wdata_o = 0.

## Timing
- Single-cycle ops have a latency of 1 edge. Throughput is 1 per cycle.
- MULT/MULTU: stallreq_o is high for 1 cycle. HI/LO update at the 2nd edge after acceptance.
- DIV/DIVU: stallreq_o is high for WIDTH+1 cycles (33 at WIDTH = 32). HI/LO update at edge WIDTH+2.
- Divide by zero: stallreq_o is high for 1 cycle. HI/LO update at the 2nd edge.
- Reset mid-operation clears everything immediately; no partial HI/LO write occurs.
- flush_i and a DONE commit in the same cycle: flush wins and there is no HI/LO write.

## Configuration
- EX_DIV_EN defined: the divider, DIV_BUSY, and the counter are built.
- EX_DIV_EN undefined:
  - DIV and DIVU behave as NOPs: no stall, HI/LO unchanged, valid_o pulses with wreg_o = 0.
  - The DIV_BUSY encoding is absent.

## Structure
- ex_pkg holds:
  - aluop codes (`EXE_*_OP`)
  - alusel result classes
  - the FSM state enum
  - RstEnable, ZeroWord
- Sub-module ex_div_iter: the restoring-divide datapath (start, dividend, divisor, signed flag → busy, quotient, remainder), wrapped in `ifdef EX_DIV_EN`.
- The top level holds the ALU, multiplier, FSM, and HI/LO.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU on the same operands → HI = 0x00000001, LO = 0xFFFFFFFE. Each stalls exactly 1 cycle.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, stallreq_o high for 33 consecutive cycles. DIVU 100 ÷ 7 → LO = 14, HI = 2.
- DIVU 0x12345678 ÷ 0 → LO = 0xFFFFFFFF, HI = 0x12345678, 1 stall cycle.
- Assert flush_i in the 10th DIV_BUSY cycle → stallreq_o low from that cycle, HI/LO retain their prior values, valid_o = 0.
- MTHI 0x00001234 then MFHI to $3 back-to-back → wdata_o = 0x00001234, wd_o = 3, wreg_o = 1.
- Assert rst in the middle of a divide → all outputs go to 0 without a clock edge. After release, ADD 5 + 7 gives wdata_o = 12.
